// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: on a start strobe, emits a burst of `count` pulses on
// out_pulse. Each pulse is HIGH_CYCLES wide and is followed by a
// LOW_CYCLES gap, including the last pulse. Progress is reported through
// remaining, busy and a one-cycle done strobe. All outputs are registered.
// Optional feature: define PULSE_BURST_STOP_EN to add the `stop` abort input.
module pulse_burst_gen #(
    parameter int unsigned HIGH_CYCLES = 1,
    parameter int unsigned LOW_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] count,
`ifdef PULSE_BURST_STOP_EN
    input  logic       stop,
`endif
    output logic       out_pulse,
    output logic       busy,
    output logic       done,
    output logic [3:0] remaining
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } state_t;

    // Phase counter counts down to zero, so it is loaded with width-1
    localparam logic [7:0] HIGH_LOAD = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0] LOW_LOAD  = 8'(LOW_CYCLES - 1);

    state_t     state;
    logic [7:0] phase;
    logic       stop_req;

    // Abort request; tied off when the stop feature is not built
`ifdef PULSE_BURST_STOP_EN
    always_comb stop_req = stop;
`else
    always_comb stop_req = 1'b0;
`endif

    // Burst sequencer: state, phase/pulse counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            out_pulse <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // stop has priority over start in the same cycle
                    if (start && !stop_req) begin
                        remaining <= count;
                        if (count != 4'd0) begin
                            phase     <= HIGH_LOAD;
                            out_pulse <= 1'b1;
                            busy      <= 1'b1;
                            state     <= HIGH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                HIGH: begin
                    if (stop_req) begin
                        // remaining stays frozen at its value at the abort
                        out_pulse <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        phase     <= '0;
                        state     <= DONE;
                    end else if (phase == 8'd0) begin
                        out_pulse <= 1'b0;
                        if (remaining != 4'd0) begin
                            remaining <= remaining - 4'd1;
                        end
                        phase <= LOW_LOAD;
                        state <= LOW;
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end

                LOW: begin
                    if (stop_req) begin
                        out_pulse <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        phase     <= '0;
                        state     <= DONE;
                    end else if (phase == 8'd0) begin
                        if (remaining != 4'd0) begin
                            out_pulse <= 1'b1;
                            phase     <= HIGH_LOAD;
                            state     <= HIGH;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    out_pulse <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Scoreboard bench for pulse_burst_gen: two instances (default widths and
// HIGH=2/LOW=1). Each accepted start pushes a burst expectation computed from
// the burst timing rules; a per-instance monitor observes the pulse train and
// compares it against the expectation when done strobes.
module tb_pulse_burst_gen;

    localparam int H0 = 1;
    localparam int L0 = 3;
    localparam int H1 = 2;
    localparam int L1 = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start;
    logic [3:0] count [2];
`ifdef PULSE_BURST_STOP_EN
    logic [1:0] stop;
`endif
    logic [1:0] out_pulse;
    logic [1:0] busy;
    logic [1:0] done;
    logic [3:0] remaining [2];

    int pcyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int cnt;
        int t0;
        int pulses;
        int busy_cycles;
        int rem;
        bit aborted;
    } exp_t;

    exp_t sbq [2][$];

    always #5 clk = ~clk;

    // Posedge counter used as the bench time base
    always @(posedge clk) pcyc <= pcyc + 1;

    pulse_burst_gen #(.HIGH_CYCLES(H0), .LOW_CYCLES(L0)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .count(count[0]),
`ifdef PULSE_BURST_STOP_EN
        .stop(stop[0]),
`endif
        .out_pulse(out_pulse[0]), .busy(busy[0]), .done(done[0]),
        .remaining(remaining[0])
    );

    pulse_burst_gen #(.HIGH_CYCLES(H1), .LOW_CYCLES(L1)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .count(count[1]),
`ifdef PULSE_BURST_STOP_EN
        .stop(stop[1]),
`endif
        .out_pulse(out_pulse[1]), .busy(busy[1]), .done(done[1]),
        .remaining(remaining[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int hc(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic int lc(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    // Expected burst outcome: stop_s = 0 means no abort, otherwise the burst
    // cycle (1-based) in which stop is sampled.
    function automatic exp_t model(input int i, input int cnt, input int t0, input int stop_s);
        exp_t e;
        int   p;
        p = hc(i) + lc(i);
        e.cnt = cnt;
        e.t0  = t0;
        if (stop_s == 0 || cnt == 0) begin
            e.pulses      = cnt;
            e.busy_cycles = cnt * p;
            e.rem         = 0;
            e.aborted     = 1'b0;
        end else begin
            e.aborted     = 1'b1;
            e.busy_cycles = stop_s;
            e.pulses      = (stop_s - 1) / p + 1;
            e.rem         = cnt;
            for (int k = 0; k < cnt; k++) begin
                // pulse k falls (and is counted off) in cycle 1 + k*p + H
                if (1 + k * p + hc(i) <= stop_s) e.rem--;
            end
        end
        return e;
    endfunction

    // Per-instance monitor: tracks the pulse train of the current burst
    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int HC = (g == 0) ? H0 : H1;
        localparam int LC = (g == 0) ? L0 : L1;
        exp_t e;
        int   busy_n, pulses, falls, hi_run, lo_run, first_busy, dc, hits;
        bit   bad_w, bad_g, bad_rem, bad_out, prev_out, prev_busy;

        task automatic clear_burst();
            busy_n = 0; pulses = 0; falls = 0; hi_run = 0; lo_run = 0;
            first_busy = -1; dc = 0; hits = 0;
            bad_w = 1'b0; bad_g = 1'b0; bad_rem = 1'b0; bad_out = 1'b0;
        endtask

        initial clear_burst();

        // Sample on the falling edge, away from DUT updates
        always @(negedge clk) begin
            if (reset) begin
                sbq[g].delete();
                clear_burst();
            end else if (sbq[g].size() == 0) begin
                if (busy[g] || done[g]) check($sformatf("unexpected_activity%0d", g), 1, 0);
            end else begin
                e = sbq[g][0];
                if (busy[g]) begin
                    if (!prev_busy) begin
                        first_busy = pcyc;
                        dc = e.cnt;
                        if (!out_pulse[g]) bad_w = 1'b1;
                    end
                    busy_n++;
                    if (out_pulse[g] && !prev_out) begin
                        pulses++;
                        if (pulses > 1 && lo_run != LC) bad_g = 1'b1;
                        hi_run = 1;
                        lo_run = 0;
                        dc = (dc - 1) & 15;
                        if (dc == 0) hits++;
                    end else if (out_pulse[g]) begin
                        hi_run++;
                    end else begin
                        if (prev_out) begin
                            falls++;
                            if (hi_run != HC) bad_w = 1'b1;
                            lo_run = 0;
                        end
                        lo_run++;
                    end
                    if (int'(remaining[g]) != e.cnt - falls) bad_rem = 1'b1;
                end else if (out_pulse[g]) begin
                    bad_out = 1'b1;
                end

                if (done[g]) begin
                    check($sformatf("done_cycle%0d", g), pcyc, e.t0 + 1 + e.busy_cycles);
                    check($sformatf("busy_cycles%0d", g), busy_n, e.busy_cycles);
                    check($sformatf("pulses%0d", g), pulses, e.pulses);
                    check($sformatf("remaining_at_done%0d", g), int'(remaining[g]), e.rem);
                    check($sformatf("out_outside_busy%0d", g), int'(bad_out), 0);
                    check($sformatf("remaining_track%0d", g), int'(bad_rem), 0);
                    if (e.busy_cycles > 0)
                        check($sformatf("first_pulse_cycle%0d", g), first_busy, e.t0 + 1);
                    if (!e.aborted) begin
                        check($sformatf("pulse_width%0d", g), int'(bad_w), 0);
                        check($sformatf("low_gap%0d", g),
                              int'(bad_g || (e.cnt > 0 && lo_run != LC)), 0);
                        if (g == 1 && e.cnt > 0)
                            check("downcounter_terminal1", hits, 1);
                    end
                    void'(sbq[g].pop_front());
                    clear_burst();
                end
            end
            prev_out  = out_pulse[g];
            prev_busy = busy[g];
            if (reset) begin
                prev_out  = 1'b0;
                prev_busy = 1'b0;
            end
        end
    end

    // Issue one burst at the current negedge; returns at the negedge after
    // done, having poked start once during the DONE cycle.
    task automatic run_burst(input int i, input int cnt, input int stop_s, input bit poke);
        int  t0;
        bit  seen;
        start[i] = 1'b1;
        count[i] = 4'(cnt);
        t0 = pcyc;
        sbq[i].push_back(model(i, cnt, t0, stop_s));
        @(negedge clk);
        start[i] = 1'b0;
        count[i] = 4'($urandom);
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done[i]) begin
                seen = 1'b1;
                break;
            end
`ifdef PULSE_BURST_STOP_EN
            stop[i] = (stop_s != 0) && (pcyc - t0 == stop_s);
`endif
            start[i] = poke && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        if (!seen) check($sformatf("done_timeout%0d", i), 0, 1);
`ifdef PULSE_BURST_STOP_EN
        stop[i] = 1'b0;
`endif
        // start during DONE must be ignored
        start[i] = 1'b1;
        count[i] = 4'($urandom_range(1, 15));
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = '0;
        count[0] = '0;
        count[1] = '0;
`ifdef PULSE_BURST_STOP_EN
        stop = '0;
`endif
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_out%0d", i), int'(out_pulse[i]), 0);
            check($sformatf("reset_busy%0d", i), int'(busy[i]), 0);
            check($sformatf("reset_done%0d", i), int'(done[i]), 0);
            check($sformatf("reset_remaining%0d", i), int'(remaining[i]), 0);
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a HIGH phase
        start[0] = 1'b1;
        count[0] = 4'd5;
        sbq[0].push_back(model(0, 5, pcyc, 0));
        @(negedge clk);
        start[0] = 1'b0;
        check("pre_reset_out", int'(out_pulse[0]), 1);
        check("pre_reset_remaining", int'(remaining[0]), 5);
        #2 reset = 1'b1;
        #1;
        check("async_reset_out", int'(out_pulse[0]), 0);
        check("async_reset_busy", int'(busy[0]), 0);
        check("async_reset_done", int'(done[0]), 0);
        check("async_reset_remaining", int'(remaining[0]), 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // Directed bursts on the default-width instance
        run_burst(0, 3, 0, 1'b0);
        run_burst(0, 0, 0, 1'b0);
        run_burst(0, 3, 0, 1'b1);
        run_burst(0, 15, 0, 1'b1);
        for (int n = 0; n < 6; n++) run_burst(0, $urandom_range(0, 15), 0, 1'b1);

        // HIGH=2 / LOW=1 instance
        run_burst(1, 15, 0, 1'b1);
        run_burst(1, 1, 0, 1'b0);
        for (int n = 0; n < 6; n++) run_burst(1, $urandom_range(0, 15), 0, 1'b1);

`ifdef PULSE_BURST_STOP_EN
        // Abort during the third HIGH phase (cycle 9 with default widths)
        run_burst(0, 8, 9, 1'b0);
        // stop and start together in IDLE: no burst
        start[0] = 1'b1;
        stop[0]  = 1'b1;
        count[0] = 4'd5;
        @(negedge clk);
        start[0] = 1'b0;
        stop[0]  = 1'b0;
        repeat (3) @(negedge clk);
        check("stop_start_idle_busy", int'(busy[0]), 0);
        check("stop_start_idle_done", int'(done[0]), 0);
        for (int n = 0; n < 4; n++) begin
            int c;
            c = $urandom_range(1, 15);
            run_burst(1, c, $urandom_range(1, c * (H1 + L1)), 1'b1);
        end
        run_burst(0, 4, 0, 1'b0);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty0", sbq[0].size(), 0);
        check("scoreboard_empty1", sbq[1].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_burst_gen.md
# pulse_burst_gen

- Transmit side of the pulse-counting chain: on a start strobe, emits a burst of exactly `count` clean pulses on `out_pulse`, with programmable high and low widths.
- Intended to drive the `in_pulse` input of the downstream 4-bit down-counters.
- Reports progress through `remaining`, a `busy` level and a one-cycle `done` strobe, so a controller can sequence bursts back to back.

## Interface
Parameters:
- HIGH_CYCLES, 1, clock cycles `out_pulse` stays high per pulse (1..255)
- LOW_CYCLES, 3, clock cycles `out_pulse` stays low after each pulse (1..255)

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high
- start  input  1  request a burst; sampled only in IDLE
- count  input  4  pulses to emit, sampled with `start`
- stop  input  1  abort the current burst (present only with the macro below)
- out_pulse  output  1  registered pulse train
- busy  output  1  high while a burst is in progress
- done  output  1  one-cycle strobe when a burst ends
- remaining  output  4  pulses not yet completed

## Operation
- FSM states: IDLE, HIGH, LOW, DONE. One 8-bit phase counter; one 4-bit pulse counter driving `remaining`.
- IDLE:
  - `start`=1 and `count`!=0: latch `count` into `remaining`, load the phase counter, go to HIGH.
  - `start`=1 and `count`==0: go to DONE; no pulse is emitted and `busy` stays low.
- HIGH: `out_pulse`=1 for HIGH_CYCLES cycles. On the last cycle, decrement `remaining` and go to LOW.
- LOW: `out_pulse`=0 for LOW_CYCLES cycles. On the last cycle, go to HIGH if `remaining`!=0, otherwise go to DONE.
  - The final pulse always receives its full low gap.
- DONE: lasts one cycle with `done`=1, then returns to IDLE.
- `busy`=1 exactly in HIGH and LOW.
- `start` is ignored in HIGH, LOW and DONE. It is never queued.
- `count` is only sampled in the cycle `start` is accepted. Later changes have no effect.
- `remaining` is a 4-bit unsigned value that never wraps. It holds its final value while in IDLE.
- Reset (asynchronous, at any time, including mid-pulse):
  - State returns to IDLE.
  - `out_pulse`=0, `busy`=0, `done`=0, `remaining`=0, phase counter=0.
  - A truncated pulse is acceptable.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `start` accepted at edge 0 gives `out_pulse`=1 from cycle 1.
- Pulse k (from 0) occupies cycles 1 + k·(HIGH_CYCLES+LOW_CYCLES) onward, lasting HIGH_CYCLES cycles.
- `busy` is high for count·(HIGH_CYCLES+LOW_CYCLES) cycles.
- `done` fires in the cycle after the last LOW cycle.
- The earliest next `start` is accepted in the cycle after `done` (IDLE).
- `count`=0: `done` in cycle 1.
- `remaining` decrements in the first cycle of each LOW phase.

## Configuration
- PULSE_BURST_STOP_EN defined:
  - The `stop` port exists.
  - `stop`=1 in HIGH or LOW: next cycle `out_pulse`=0 and the state goes to DONE (`done` strobes). `remaining` freezes at its value at the abort.
  - `stop` in IDLE or DONE is ignored.
  - `stop` and `start` in the same IDLE cycle: `stop` has priority and no burst starts.
- PULSE_BURST_STOP_EN undefined:
  - No `stop` port.
  - Every accepted burst runs to completion; only `reset` can interrupt it.

## Test plan
- Reset mid-HIGH with defaults and `count`=5:
  - `out_pulse`, `busy`, `done` drop to 0 immediately, without waiting for a clock edge.
  - `remaining`=0 and the FSM is in IDLE.
- Defaults, `count`=3, `start` at edge 0:
  - `out_pulse` high in cycles 1, 5, 9; `busy` high in cycles 1–12.
  - `done` in cycle 13; `remaining` steps 3→2→1→0 in cycles 2, 6, 10.
- `count`=0 with `start`: `done` in cycle 1, `busy` never high, `out_pulse` never high.
- HIGH_CYCLES=2, LOW_CYCLES=1, `count`=15:
  - 15 pulses, each 2 cycles wide; `done` after 45 busy cycles.
  - Output feeds a 4-bit down-counter loaded with 15; that counter wraps exactly once.
- `start` pulsed during busy and during DONE: both ignored, pulse count unchanged.
  - A `start` in the cycle after `done` is accepted.
- With PULSE_BURST_STOP_EN, `count`=8, `stop` during the 3rd HIGH phase:
  - `out_pulse` low next cycle, `done` strobes, `remaining` holds 6.
